// File: rtl/led_pattern_pkg.sv
// rtl/led_pattern_pkg.sv - shared mode encoding and helpers for the LED pattern generator
package led_pattern_pkg;

  // Mode select values as presented on the 3-bit switch bank
  typedef enum logic [2:0] {
    OFF    = 3'd0,
    ON     = 3'd1,
    RUN_L  = 3'd2,
    RUN_R  = 3'd3,
    BOUNCE = 3'd4,
    COUNT  = 3'd5,
    BLINK  = 3'd6,
    BAR    = 3'd7
  } mode_t;

  localparam int unsigned MAX_LED_W = 32;
  localparam int unsigned MAX_DIV   = 65535;

  // Prescaler counter width; a DIV of 1 still keeps a one-bit counter
  function automatic int cnt_width(input int div);
    return (div > 1) ? $clog2(div) : 1;
  endfunction

  // Pattern loaded on mode entry, built at full width; the caller truncates to its LED count
  function automatic logic [MAX_LED_W-1:0] init_pattern(input mode_t m, input int unsigned w);
    logic [MAX_LED_W-1:0] ones;
    logic [MAX_LED_W-1:0] pat;
    ones = (w >= MAX_LED_W) ? {MAX_LED_W{1'b1}} : ((32'd1 << w) - 32'd1);
    case (m)
      ON, BLINK:     pat = ones;
      RUN_L, BOUNCE: pat = 32'd1;
      RUN_R:         pat = 32'd1 << (w - 32'd1);
      default:       pat = '0;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/led_pattern_gen_tick_div.sv
// rtl/led_pattern_gen_tick_div.sv - step-rate prescaler producing one tick every DIV enabled cycles
module tick_div
  import led_pattern_pkg::*;
#(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CNT_W = cnt_width(DIV);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] pre_cnt;

  // Tick is combinational so the step lands on the same edge the counter wraps
  assign tick = en && (pre_cnt == LAST);

  // Clear beats enable; with enable low the count (and so the step phase) is held
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      pre_cnt <= '0;
    end else if (en) begin
      pre_cnt <= tick ? '0 : pre_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/led_pattern_gen.sv
// rtl/led_pattern_gen.sv - switch-selected animated LED pattern generator with prescaled step rate
module led_pattern_gen
  import led_pattern_pkg::*;
#(
  parameter int LED_W = 8,
  parameter int DIV   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [2:0]       switch,
  output logic [LED_W-1:0] led
);

  if (LED_W < 2 || LED_W > MAX_LED_W) begin : g_bad_led_w
    $error("led_pattern_gen: LED_W out of range 2..32");
  end
  if (DIV < 1 || DIV > MAX_DIV) begin : g_bad_div
    $error("led_pattern_gen: DIV out of range 1..65535");
  end

  mode_t            mode_q;
  logic             dir;
  logic             mode_chg;
  logic             tick;
  logic [LED_W-1:0] init_led;
  logic [LED_W-1:0] next_led;
  logic             next_dir;

  // Any difference between the switches and the latched mode is a mode entry, even while paused
  assign mode_chg = (mode_t'(switch) != mode_q);
  assign init_led = LED_W'(init_pattern(mode_t'(switch), LED_W));

  tick_div #(
    .DIV (DIV)
  ) u_tick_div (
    .clk  (clk),
    .rst  (rst),
    .en   (enable),
    .clr  (mode_chg),
    .tick (tick)
  );

  // Next animation frame for the latched mode; dir only matters for the bounce
  always_comb begin
    next_led = led;
    next_dir = dir;
    case (mode_q)
      OFF:   next_led = '0;
      ON:    next_led = '1;
      RUN_L: next_led = {led[LED_W-2:0], led[LED_W-1]};
      RUN_R: next_led = {led[0], led[LED_W-1:1]};
      BOUNCE: begin
        if (!dir) begin
          if (led[LED_W-1]) begin
            next_led = led >> 1;
            next_dir = 1'b1;
          end else begin
            next_led = led << 1;
          end
        end else begin
          if (led[0]) begin
            next_led = led << 1;
            next_dir = 1'b0;
          end else begin
            next_led = led >> 1;
          end
        end
      end
      COUNT: next_led = led + LED_W'(1);
      BLINK: next_led = ~led;
      BAR:   next_led = (&led) ? '0 : {led[LED_W-2:0], 1'b1};
      default: next_led = '0;
    endcase
  end

  // Mode entry outranks stepping; the prescaler tick already folds in enable
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q <= OFF;
      dir    <= 1'b0;
      led    <= '0;
    end else if (mode_chg) begin
      mode_q <= mode_t'(switch);
      dir    <= 1'b0;
      led    <= init_led;
    end else if (tick) begin
      led    <= next_led;
      dir    <= next_dir;
    end
  end

endmodule

// File: tb/tb_led_pattern_gen.sv
// tb/tb_led_pattern_gen.sv - randomized self-checking bench for led_pattern_gen against a step-index model
module tb_led_pattern_gen;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         enable = 1'b1;
  logic [2:0]   switch = 3'd0;
  logic [W-1:0] led1;
  logic [W-1:0] led3;

  int checks = 0;
  int errors = 0;

  // Reference model: current mode and enabled cycles since the last mode load
  int m_mode = 0;
  int m_cnt  = 0;

  always #5 clk = ~clk;

  led_pattern_gen #(.LED_W(W), .DIV(1)) dut1 (
    .clk    (clk),
    .rst    (rst),
    .enable (enable),
    .switch (switch),
    .led    (led1)
  );

  led_pattern_gen #(.LED_W(W), .DIV(3)) dut3 (
    .clk    (clk),
    .rst    (rst),
    .enable (enable),
    .switch (switch),
    .led    (led3)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Pattern shown after k steps in mode m, straight from the mode definitions
  function automatic logic [W-1:0] pat(input int m, input int k);
    int p;
    logic [31:0] v;
    case (m)
      1: v = (1 << W) - 1;
      2: v = 1 << (k % W);
      3: v = (1 << (W - 1)) >> (k % W);
      4: begin
        p = k % (2 * (W - 1));
        if (p > W - 1) p = 2 * (W - 1) - p;
        v = 1 << p;
      end
      5: v = k % (1 << W);
      6: v = (k % 2 == 1) ? 0 : (1 << W) - 1;
      7: v = (1 << (k % (W + 1))) - 1;
      default: v = 0;
    endcase
    return v[W-1:0];
  endfunction

  task automatic cycle(input logic r, input logic e, input logic [2:0] s);
    @(negedge clk);
    rst = r;
    enable = e;
    switch = s;
    @(posedge clk);
    #1;
    if (r) begin
      m_mode = 0;
      m_cnt = 0;
    end else if (int'(s) != m_mode) begin
      m_mode = int'(s);
      m_cnt = 0;
    end else if (e) begin
      m_cnt++;
    end
    check_eq("led_div1", {24'd0, led1}, {24'd0, pat(m_mode, m_cnt)});
    check_eq("led_div3", {24'd0, led3}, {24'd0, pat(m_mode, m_cnt / 3)});
  endtask

  initial begin
    int seen_top;
    int seen_bot;
    int len;
    logic [2:0] s;

    cycle(1, 1, 0);
    cycle(1, 1, 0);
    check_eq("reset_led", {24'd0, led1}, 32'h00);

    cycle(0, 1, 2);
    check_eq("runl_init", {24'd0, led1}, 32'h01);
    cycle(0, 1, 2);
    check_eq("runl_step1", {24'd0, led1}, 32'h02);
    for (int i = 0; i < 10; i++) cycle(0, 1, 2);

    cycle(0, 1, 4);
    for (int i = 0; i < 6; i++) cycle(0, 1, 4);
    seen_top = 0;
    seen_bot = 0;
    for (int i = 0; i < 14; i++) begin
      cycle(0, 1, 4);
      if (led1 == 8'h80) seen_top++;
      if (led1 == 8'h01) seen_bot++;
    end
    check_eq("bounce_top_once", seen_top, 1);
    check_eq("bounce_bot_once", seen_bot, 1);

    for (int i = 0; i < 260; i++) cycle(0, 1, 5);
    for (int i = 0; i < 12; i++) cycle(0, 1, 7);

    cycle(0, 1, 3);
    check_eq("runr_init_div3", {24'd0, led3}, 32'h80);
    for (int i = 0; i < 4; i++) cycle(0, 1, 3);
    for (int i = 0; i < 5; i++) cycle(0, 0, 3);
    for (int i = 0; i < 10; i++) cycle(0, 1, 3);

    for (int i = 0; i < 4; i++) cycle(0, 1, 6);
    cycle(0, 0, 6);
    cycle(0, 0, 1);
    check_eq("freeze_on", {24'd0, led1}, 32'hFF);
    cycle(0, 0, 1);
    cycle(0, 0, 2);
    check_eq("freeze_runl", {24'd0, led1}, 32'h01);
    for (int i = 0; i < 3; i++) cycle(0, 0, 2);
    check_eq("freeze_hold", {24'd0, led1}, 32'h01);
    for (int i = 0; i < 5; i++) cycle(0, 1, 2);

    cycle(0, 1, 4);
    cycle(0, 1, 4);
    cycle(1, 1, 4);
    check_eq("midreset_led", {24'd0, led1}, 32'h00);
    cycle(0, 1, 4);
    check_eq("midreset_init", {24'd0, led1}, 32'h01);

    for (int i = 0; i < 40; i++) begin
      cycle(0, ($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)));
    end

    for (int n = 0; n < 30; n++) begin
      s = 3'($urandom_range(0, 7));
      len = $urandom_range(1, 25);
      for (int i = 0; i < len; i++) begin
        cycle(($urandom_range(0, 60) == 0), ($urandom_range(0, 4) != 0), s);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
